conv_window_gen: RTL and testbench

- Streaming 5x5 sliding-window generator; the producer side of the conv layer's 25-input window interface.
- Accepts one raster-order pixel per cycle from the image source (28x28, 32-bit signed) and emits every valid 5x5 window: 24x24 = 576 windows per frame.
- Built from K-1 line buffers plus a KxK register window, with a valid/ready handshake on both sides.
- The window output drives data_00..data_44 of the conv layer directly.

---
 rtl/conv_window_gen.sv | 163 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 line buffers feed a KxK register window.
// Optional macro CONV_WIN_COORD_EN adds win_row/win_col (top-left coordinate of each window).
module conv_window_gen #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 32,
   parameter int K      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K*K*DATA_W-1:0] win_data,
   output logic                  frame_done,
`ifdef CONV_WIN_COORD_EN
   output logic [4:0]            win_row,
   output logic [4:0]            win_col,
`endif
   output logic [1:0]            dbg_state_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              in_xfer, out_xfer, emit;
   logic              last_col, last_row;
   logic [DATA_W-1:0] lb_q    [K-1][IMG_W];
   logic [DATA_W-1:0] win_q   [K][K];
   logic [DATA_W-1:0] new_col [K];

   // Transfers happen when valid and ready are both high at the rising edge; a held
   // window blocks input (no skid buffer), and DRAIN blocks input until the last window leaves.
   assign in_ready  = (!out_valid_q || out_ready) && (state_q != ST_DRAIN);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid_q && out_ready;
   assign last_col  = (col_q == CW'(IMG_W - 1));
   assign last_row  = (row_q == RW'(IMG_H - 1));

   assign out_valid   = out_valid_q;
   assign frame_done  = frame_done_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      out_valid_d  = out_valid_q && !out_ready;
      frame_done_d = 1'b0;
      emit         = 1'b0;
      if (in_xfer) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         emit = (state_q == ST_STREAM) && (col_q >= CW'(K - 1));
      end
      if (emit) out_valid_d = 1'b1;
      case (state_q)
         ST_FILL: begin
            if (in_xfer && last_col && (row_q == RW'(K - 2))) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (in_xfer && last_col && last_row) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_xfer) begin
               state_d      = ST_FILL;
               frame_done_d = 1'b1;
               col_d        = '0;
               row_d        = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_FILL;
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers are plain memory: every entry is rewritten before a window can read it.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         for (int k = 0; k < K - 2; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
         lb_q[K-2][col_q] <= in_data;
      end
   end

   always_comb begin
      for (int r = 0; r < K - 1; r++) new_col[r] = lb_q[r][col_q];
      new_col[K-1] = in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end else if (in_xfer) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
            win_q[r][K-1] <= new_col[r];
         end
      end
   end

   for (genvar gr = 0; gr < K; gr++) begin : g_row
      for (genvar gc = 0; gc < K; gc++) begin : g_col
         assign win_data[(gr*K+gc)*DATA_W +: DATA_W] = win_q[gr][gc];
      end
   end

`ifdef CONV_WIN_COORD_EN
   logic [4:0] win_row_q, win_col_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (emit) begin
         win_row_q <= 5'(row_q - RW'(K - 1));
         win_col_q <= 5'(col_q - CW'(K - 1));
      end
   end

   assign win_row = win_row_q;
   assign win_col = win_col_q;
`endif

   a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(win_data)));

   a_drain_blocks_input: assert property (@(posedge clk) disable iff (!rst)
      (state_q == ST_DRAIN) |-> !in_ready);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: scoreboard over full frames plus a table of spot checks.
module tb_conv_window_gen;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int DATA_W = 32;
   localparam int K      = 5;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int W      = K * K * DATA_W;
   localparam int BUDGET = 20000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready, out_valid, frame_done;
   logic [W-1:0]      win_data;
   logic [1:0]        dbg_state;
`ifdef CONV_WIN_COORD_EN
   logic [4:0]        win_row, win_col;
`endif

   always #5 clk = ~clk;

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .K(K)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .win_data   (win_data),
      .frame_done (frame_done),
`ifdef CONV_WIN_COORD_EN
      .win_row    (win_row),
      .win_col    (win_col),
`endif
      .dbg_state_o(dbg_state)
   );

   typedef struct {
      int                phase;
      int                idx;
      int                slot;
      logic [DATA_W-1:0] exp;
   } vec_t;

   int                tests = 0;
   int                fails = 0;
   logic [DATA_W-1:0] pix_val [NPIX];
   logic [W-1:0]      exp_q[$];
   int                src_q[$];
   logic [W-1:0]      cap[$];
   vec_t              vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model_win(input int p);
      int r = p / IMG_W;
      int c = p % IMG_W;
      logic [W-1:0] w = '0;
      for (int rr = 0; rr < K; rr++)
         for (int cc = 0; cc < K; cc++)
            w[(rr*K+cc)*DATA_W +: DATA_W] = pix_val[(r-K+1+rr)*IMG_W + (c-K+1+cc)];
      return w;
   endfunction

   task automatic fill_pix(input int offset);
      for (int i = 0; i < NPIX; i++) pix_val[i] = DATA_W'(i + offset);
   endtask

   // Drives npix raster pixels (wrapping per frame), accepts windows, scoreboards them.
   task automatic stream(input int npix, input int stall_src, output int nwin, output int nfd);
      int sent = 0;
      int cyc = 0;
      int tail = 0;
      int stall_cnt = 0;
      int first_cyc = -1;
      int cyc_116 = -1;
      int p;
      logic [W-1:0] held = '0;
      bit in_x, out_x;
      nwin = 0;
      nfd  = 0;
      cap.delete();
      exp_q.delete();
      src_q.delete();
      while (tail < 3 && cyc < BUDGET) begin
         @(negedge clk);
         p         = sent % NPIX;
         in_valid  = (sent < npix);
         in_data   = in_valid ? pix_val[p] : '0;
         out_ready = 1'b1;
         if (out_valid && src_q.size() > 0 && src_q[0] == stall_src && stall_cnt < 3) begin
            out_ready = 1'b0;
            if (stall_cnt == 0) held = win_data;
            else check("stall_hold", win_data, held);
            stall_cnt++;
         end
         #1;
         if (!out_ready) check("stall_in_ready", W'(in_ready), W'(0));
         in_x  = in_valid && in_ready;
         out_x = out_valid && out_ready;
         if (frame_done) nfd++;
         if (out_valid && first_cyc < 0) first_cyc = cyc;
         if (out_x) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_window actual=%0h required=none", win_data);
            end else begin
               check("window", win_data, exp_q[0]);
`ifdef CONV_WIN_COORD_EN
               check("win_row", W'(win_row), W'(src_q[0] / IMG_W - (K - 1)));
               check("win_col", W'(win_col), W'(src_q[0] % IMG_W - (K - 1)));
`endif
               void'(exp_q.pop_front());
               void'(src_q.pop_front());
            end
            cap.push_back(win_data);
            nwin++;
         end
         if (in_x) begin
            if (p == 116 && cyc_116 < 0) cyc_116 = cyc;
            if (p / IMG_W >= K - 1 && p % IMG_W >= K - 1) begin
               exp_q.push_back(model_win(p));
               src_q.push_back(p);
            end
            sent++;
         end
         if (sent >= npix && !out_valid && exp_q.size() == 0) tail++;
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= BUDGET) begin
         tests++;
         fails++;
         $display("FAIL stream_timeout actual=%0d cycles required=completion", cyc);
      end
      if (npix > 116) check("first_latency", W'(first_cyc), W'(cyc_116 + 1));
   endtask

   task automatic apply_vecs(input int phase);
      logic [W-1:0] w;
      foreach (vecs[i]) begin
         if (vecs[i].phase == phase) begin
            if (vecs[i].idx >= cap.size()) begin
               tests++;
               fails++;
               $display("FAIL vec_p%0d_w%0d actual=missing required=%0h",
                        phase, vecs[i].idx, vecs[i].exp);
            end else begin
               w = cap[vecs[i].idx];
               check($sformatf("vec_p%0d_w%0d_s%0d", phase, vecs[i].idx, vecs[i].slot),
                     W'(w[vecs[i].slot*DATA_W +: DATA_W]), W'(vecs[i].exp));
            end
         end
      end
   endtask

   initial begin
      int nwin, nfd;

      vecs.push_back('{1, 0, 0, 32'd0});
      vecs.push_back('{1, 0, 4, 32'd4});
      vecs.push_back('{1, 0, 20, 32'd112});
      vecs.push_back('{1, 0, 24, 32'd116});
      vecs.push_back('{1, 23, 24, 32'd139});
      vecs.push_back('{1, 24, 0, 32'd28});
      vecs.push_back('{1, 24, 24, 32'd144});
      vecs.push_back('{1, 72, 24, 32'd200});
      vecs.push_back('{1, 73, 24, 32'd201});
      vecs.push_back('{1, 575, 0, 32'd667});
      vecs.push_back('{1, 575, 24, 32'd783});
      vecs.push_back('{2, 0, 0, 32'h8000_0000});
      vecs.push_back('{2, 0, 1, 32'd1});
      vecs.push_back('{2, 0, 24, 32'hFFFF_FFFF});
      vecs.push_back('{3, 0, 0, 32'd0});
      vecs.push_back('{3, 0, 24, 32'd116});
      vecs.push_back('{3, 575, 24, 32'd783});
      vecs.push_back('{4, 0, 0, 32'd0});
      vecs.push_back('{4, 576, 0, 32'd0});
      vecs.push_back('{4, 576, 24, 32'd116});
      vecs.push_back('{4, 1151, 24, 32'd783});

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_frame_done", W'(frame_done), W'(0));
      check("rst_win_data", win_data, W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_state", W'(dbg_state), W'(0));
      rst = 1'b1;

      // Phase 1: full frame, value = row*28+col, 3-cycle stall on the window ending at pixel 200
      fill_pix(0);
      stream(NPIX, 200, nwin, nfd);
      check("p1_windows", W'(nwin), W'(576));
      check("p1_frame_done", W'(nfd), W'(1));
      apply_vecs(1);

      // Phase 2: signed extremes pass through bit-exact
      fill_pix(0);
      pix_val[0]   = 32'h8000_0000;
      pix_val[116] = 32'hFFFF_FFFF;
      stream(NPIX, -1, nwin, nfd);
      check("p2_windows", W'(nwin), W'(576));
      apply_vecs(2);

      // Phase 3: partial frame, pending window, async reset, then a clean frame
      fill_pix(5000);
      stream(300, -1, nwin, nfd);
      check("p3_partial_windows", W'(nwin), W'(160));
      check("p3_partial_frame_done", W'(nfd), W'(0));
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = pix_val[300];
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("p3_pending_valid", W'(out_valid), W'(1));
      rst = 1'b0;
      #1;
      check("p3_rst_out_valid", W'(out_valid), W'(0));
      check("p3_rst_win_data", win_data, W'(0));
      check("p3_rst_frame_done", W'(frame_done), W'(0));
      check("p3_rst_state", W'(dbg_state), W'(0));
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b1;
      fill_pix(0);
      stream(NPIX, -1, nwin, nfd);
      check("p3_windows", W'(nwin), W'(576));
      check("p3_frame_done", W'(nfd), W'(1));
      apply_vecs(3);

      // Phase 4: two frames back to back with no idle input cycles
      stream(2 * NPIX, -1, nwin, nfd);
      check("p4_windows", W'(nwin), W'(1152));
      check("p4_frame_done", W'(nfd), W'(2));
      apply_vecs(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
